sub_bytes: RTL and testbench

// - AES SubBytes stage: applies the FIPS-197 S-box independently to every

---
 rtl/sub_bytes_if.sv | 33 +++
 rtl/sub_bytes.sv | 118 +++++++++++
 tb/tb_sub_bytes.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sub_bytes_if.sv
// sub_bytes_if: column handshake bundle for the AES SubBytes stage.
// The inv lane-mode bit exists only when INV_SBOX_EN is defined.
interface sub_bytes_if #(
  parameter int NUM_BYTES = 4
);
  logic                   in_valid;
  logic [8*NUM_BYTES-1:0] in_data;
`ifdef INV_SBOX_EN
  logic                   inv;
`endif
  logic                   out_valid;
  logic [8*NUM_BYTES-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
`ifdef INV_SBOX_EN
    output inv,
`endif
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef INV_SBOX_EN
    input  inv,
`endif
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sub_bytes.sv
// sub_bytes: registered AES S-box over NUM_BYTES independent lanes.
// Define INV_SBOX_EN to add the inverse S-box selected by bus.inv.
module sub_bytes #(
  parameter int NUM_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sub_bytes_if.slave  bus
);

  localparam int W = 8 * NUM_BYTES;

  function automatic logic [7:0] rotl(
    input logic [7:0] v,
    input int         n
  );
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // x^254 is the field inverse and naturally maps 0 to 0
  function automatic logic [7:0] ginv(
    input logic [7:0] v
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = v;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_box(
    input logic [7:0] v
  );
    logic [7:0] b;
    b = ginv(v);
    return b ^ rotl(b, 1) ^ rotl(b, 2)
             ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_box(
    input logic [7:0] v
  );
    logic [7:0] b;
    b = rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [7:0] lane(
    input logic [7:0] v,
    input logic       inv
  );
    logic [7:0] r;
    unique case (1'b1)
      inv:     r = inv_box(v);
      default: r = fwd_box(v);
    endcase
    return r;
  endfunction

  logic         mode;
  logic [W-1:0] sub;
  logic         vld_q;
  logic [W-1:0] dat_q;

`ifdef INV_SBOX_EN
  assign mode = bus.inv;
`else
  assign mode = 1'b0;
`endif

  always_comb begin
    sub = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      sub[8*i +: 8] = lane(bus.in_data[8*i +: 8], mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) dat_q <= sub;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = dat_q;

endmodule

// File: tb/tb_sub_bytes.sv
// tb_sub_bytes: directed vectors for the SubBytes stage.
// Build with INV_SBOX_EN defined to also exercise the inverse box.
module tb_sub_bytes;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  sub_bytes_if #(.NUM_BYTES(4)) bus ();

  sub_bytes #(.NUM_BYTES(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        v,
    input logic [31:0] d
  );
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    drive(1'b0, 32'h0);
`ifdef INV_SBOX_EN
    bus.inv = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_data", bus.out_data, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    drive(1'b1, 32'hE99AA019);
    step();
    check("col_data", bus.out_data, 32'h1EB8E0D4);
    check("col_valid", {31'b0, bus.out_valid}, 32'h1);

    drive(1'b1, 32'h0153FF00);
    step();
    check("corner", bus.out_data, 32'h7CED1663);

    drive(1'b1, 32'h11100201);
    step();
    check("misc", bus.out_data, 32'h82CA777C);

    drive(1'b1, 32'h00000000);
    step();
    check("b2b0_data", bus.out_data, 32'h63636363);
    check("b2b0_valid", {31'b0, bus.out_valid}, 32'h1);
    drive(1'b1, 32'hFFFFFFFF);
    step();
    check("b2b1_data", bus.out_data, 32'h16161616);
    check("b2b1_valid", {31'b0, bus.out_valid}, 32'h1);

    drive(1'b0, 32'hE99AA019);
    step();
    check("hold_valid", {31'b0, bus.out_valid}, 32'h0);
    check("hold_data", bus.out_data, 32'h16161616);
    step();
    check("hold2_data", bus.out_data, 32'h16161616);

    drive(1'b1, 32'hE99AA019);
    step();
    check("pre_rst", bus.out_data, 32'h1EB8E0D4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("mid_rst_data", bus.out_data, 32'h0);
    step();
    check("rst_hold", bus.out_data, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 32'h0153FF00);
    step();
    check("post_rst", bus.out_data, 32'h7CED1663);
    check("post_rst_v", {31'b0, bus.out_valid}, 32'h1);

`ifdef INV_SBOX_EN
    bus.inv = 1'b1;
    drive(1'b1, 32'h1EB8E0D4);
    step();
    check("inv_col", bus.out_data, 32'hE99AA019);
    for (int k = 0; k < 64; k++) begin
      logic [31:0] orig;
      logic [31:0] fwd;
      orig = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      bus.inv = 1'b0;
      drive(1'b1, orig);
      step();
      fwd = bus.out_data;
      bus.inv = 1'b1;
      drive(1'b1, fwd);
      step();
      check("inv_sweep", bus.out_data, orig);
    end
    bus.inv = 1'b0;
`endif

    drive(1'b0, 32'h0);
    step();
    check("end_valid", {31'b0, bus.out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
